// File: rtl/hex_display_writer.sv
// hex_display_writer
//
// Avalon-MM master that updates the seven-segment hex PIO slaves directly
// from hardware. A start request latches a packed hex value. The block then
// issues one single-word write per digit, in order, to consecutive PIO
// windows. Each write carries the active-low segment code of its nibble.
// A write stalled by waitrequest for TIMEOUT_CYCLES edges aborts the
// sequence, and error pulses. Digits not yet written keep their old content.
//
// Parameters
//   NUM_DIGITS      digits written per sequence (1..8)
//   BASE_ADDR       byte address of digit 0's PIO data register
//   STRIDE          byte address step between consecutive digit slaves
//   TIMEOUT_CYCLES  max stalled edges tolerated per write (1..65535)
//
// Ports
//   clk              rising-edge clock
//   reset            asynchronous, active-high reset
//   start            update request, sampled only while idle
//   value            packed digits, nibble i goes to digit i
//   busy             high from the accepted start through FINISH/ABORT
//   done             one-cycle pulse: all digits written
//   error            one-cycle pulse: sequence aborted on timeout
//   avm_address      byte address of the current write
//   avm_write        write request
//   avm_writedata    {24'b0, segment code}
//   avm_byteenable   4'b0001 while writing, 4'b0000 otherwise
//   avm_waitrequest  slave stall

module hex_display_writer #(
    parameter int          NUM_DIGITS     = 6,
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter logic [31:0] STRIDE         = 32'h0000_0010,
    parameter int          TIMEOUT_CYCLES = 255
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [4*NUM_DIGITS-1:0] value,
    output logic                    busy,
    output logic                    done,
    output logic                    error,
    output logic [31:0]             avm_address,
    output logic                    avm_write,
    output logic [31:0]             avm_writedata,
    output logic [3:0]              avm_byteenable,
    input  logic                    avm_waitrequest
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WRITE  = 2'd1,
        FINISH = 2'd2,
        ABORT  = 2'd3
    } state_t;

    state_t                  state_q;
    logic [4*NUM_DIGITS-1:0] shadow_q;
    logic [2:0]              idx_q;
    logic [15:0]             cnt_q;
    logic                    write_q;
    logic [31:0]             addr_q;
    logic [7:0]              data_q;
    logic [3:0]              be_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    error_q;

    logic [2:0]              idx_d;
    logic [7:0]              seg_d;
    logic                    last_digit;
    logic                    timed_out;

    // Active-low segment code; bit 7 is the decimal point, kept off.
    function automatic logic [7:0] seg(input logic [3:0] n);
        case (n)
            4'h0: seg = 8'hC0;
            4'h1: seg = 8'hF9;
            4'h2: seg = 8'hA4;
            4'h3: seg = 8'hB0;
            4'h4: seg = 8'h99;
            4'h5: seg = 8'h92;
            4'h6: seg = 8'h82;
            4'h7: seg = 8'hF8;
            4'h8: seg = 8'h80;
            4'h9: seg = 8'h90;
            4'hA: seg = 8'h88;
            4'hB: seg = 8'h83;
            4'hC: seg = 8'hC6;
            4'hD: seg = 8'hA1;
            4'hE: seg = 8'h86;
            default: seg = 8'h8E;
        endcase
    endfunction

    function automatic logic [3:0] nibble(input logic [4*NUM_DIGITS-1:0] v,
                                          input logic [2:0]              i);
        logic [4*NUM_DIGITS-1:0] s;
        s = v >> {i, 2'b00};
        return s[3:0];
    endfunction

    // Next digit's code is prepared ahead so that the following write can be
    // presented right after acceptance, with no idle gap on the bus.
    always_comb begin
        idx_d      = idx_q + 3'd1;
        seg_d      = seg(nibble(shadow_q, idx_d));
        last_digit = (idx_q == 3'(NUM_DIGITS - 1));
        // cnt_q counts stalled edges already seen; this edge is one more.
        timed_out  = (cnt_q == 16'(TIMEOUT_CYCLES - 1));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            shadow_q <= '0;
            idx_q    <= '0;
            cnt_q    <= '0;
            write_q  <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            be_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            error_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        shadow_q <= value;
                        idx_q    <= '0;
                        cnt_q    <= '0;
                        write_q  <= 1'b1;
                        addr_q   <= BASE_ADDR;
                        data_q   <= seg(value[3:0]);
                        be_q     <= 4'b0001;
                        busy_q   <= 1'b1;
                        state_q  <= WRITE;
                    end
                end

                WRITE: begin
                    if (!avm_waitrequest) begin
                        cnt_q <= '0;
                        if (last_digit) begin
                            write_q <= 1'b0;
                            addr_q  <= '0;
                            data_q  <= '0;
                            be_q    <= '0;
                            done_q  <= 1'b1;
                            state_q <= FINISH;
                        end else begin
                            idx_q  <= idx_d;
                            addr_q <= addr_q + STRIDE;
                            data_q <= seg_d;
                        end
                    end else if (timed_out) begin
                        cnt_q   <= '0;
                        write_q <= 1'b0;
                        addr_q  <= '0;
                        data_q  <= '0;
                        be_q    <= '0;
                        error_q <= 1'b1;
                        state_q <= ABORT;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end

                FINISH, ABORT: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end

                default: begin
                    write_q <= 1'b0;
                    be_q    <= '0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign error          = error_q;
    assign avm_address    = addr_q;
    assign avm_write      = write_q;
    assign avm_writedata  = {24'b0, data_q};
    assign avm_byteenable = be_q;

endmodule

// File: tb/tb_hex_display_writer.sv
module tb_hex_display_writer;

    localparam int          ND   = 6;
    localparam logic [31:0] BASE = 32'h0000_0040;
    localparam logic [31:0] STR  = 32'h0000_0010;
    localparam int          TO   = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [4*ND-1:0] value;
    logic          busy, done, error;
    logic [31:0]   avm_address;
    logic          avm_write;
    logic [31:0]   avm_writedata;
    logic [3:0]    avm_byteenable;
    logic          avm_waitrequest;

    int n_tests = 0;
    int n_fail  = 0;
    int stall_len [ND];

    logic [7:0] SEG [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                             8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    hex_display_writer #(
        .NUM_DIGITS     (ND),
        .BASE_ADDR      (BASE),
        .STRIDE         (STR),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .value           (value),
        .busy            (busy),
        .done            (done),
        .error           (error),
        .avm_address     (avm_address),
        .avm_write       (avm_write),
        .avm_writedata   (avm_writedata),
        .avm_byteenable  (avm_byteenable),
        .avm_waitrequest (avm_waitrequest)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_addr(input int k);
        return BASE + 32'(k) * STR;
    endfunction

    function automatic logic [31:0] exp_data(input logic [4*ND-1:0] v, input int k);
        logic [4*ND-1:0] s;
        s = v >> (4 * k);
        return {24'b0, SEG[s[3:0]]};
    endfunction

    // Called at a negedge with the DUT idle; start is applied for the next edge
    // (cycle 0). Returns at the negedge of the first idle cycle afterwards.
    task automatic run_seq(input logic [4*ND-1:0] v, input bit noisy, input bit hold);
        int acc = 0, sc = 0, cyc = 0, done_cyc = -1, err_cyc = -1;
        int kt = -1, sum = 0, exp_end, busy_bad = 0, be_bad = 0, hold_bad = 0, extra = 0;
        bit wr, prev_stall = 0, ended = 0;
        logic [31:0] pa = '0, pd = '0;
        for (int k = 0; k < ND; k++) begin
            if (kt < 0) begin
                if (stall_len[k] >= TO) kt = k;
                else sum += stall_len[k];
            end
        end
        exp_end = (kt < 0) ? ND + 1 + sum : 1 + kt + sum + TO;

        start = 1'b1;
        value = v;
        avm_waitrequest = 1'b0;
        while (!ended && cyc < 200) begin
            @(negedge clk);
            cyc++;
            start = hold ? 1'b1 : (noisy ? 1'($urandom_range(0, 1)) : 1'b0);
            if (noisy) value = 24'($urandom);
            if (busy !== 1'b1) busy_bad++;
            if (avm_byteenable !== (avm_write ? 4'b0001 : 4'b0000)) be_bad++;
            if (prev_stall && avm_write && (avm_address !== pa || avm_writedata !== pd)) hold_bad++;
            prev_stall = 0;
            if (avm_write) begin
                if (acc < ND && sc < stall_len[acc]) begin
                    wr = 1'b1;
                    sc++;
                    prev_stall = 1;
                    pa = avm_address;
                    pd = avm_writedata;
                end else begin
                    wr = 1'b0;
                    if (acc < ND) begin
                        chk($sformatf("addr%0d", acc), avm_address, exp_addr(acc));
                        chk($sformatf("data%0d", acc), avm_writedata, exp_data(v, acc));
                    end else begin
                        extra++;
                    end
                    acc++;
                    sc = 0;
                end
            end else begin
                wr = 1'($urandom_range(0, 1));
            end
            avm_waitrequest = wr;
            if (done) begin
                if (done_cyc < 0) done_cyc = cyc;
                ended = 1;
            end
            if (error) begin
                if (err_cyc < 0) err_cyc = cyc;
                chk("write_at_error", 32'(avm_write), 32'd0);
                ended = 1;
            end
            if (ended && !hold) start = 1'b0;
        end
        chk("seq_ended", 32'(ended), 32'd1);

        @(negedge clk);
        chk("busy_idle", 32'(busy), 32'd0);
        chk("done_idle", 32'(done), 32'd0);
        chk("error_idle", 32'(error), 32'd0);
        chk("write_idle", 32'(avm_write), 32'd0);
        avm_waitrequest = 1'b0;
        if (!hold) start = 1'b0;

        chk("num_writes", 32'(acc), 32'((kt < 0) ? ND : kt));
        chk("end_cycle", 32'((kt < 0) ? done_cyc : err_cyc), 32'(exp_end));
        chk("other_pulse", 32'((kt < 0) ? err_cyc : done_cyc), 32'hFFFF_FFFF);
        chk("busy_during", 32'(busy_bad), 32'd0);
        chk("byteenable", 32'(be_bad), 32'd0);
        chk("stall_hold", 32'(hold_bad), 32'd0);
        chk("extra_writes", 32'(extra), 32'd0);
    endtask

    task automatic clear_stalls();
        for (int k = 0; k < ND; k++) stall_len[k] = 0;
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        value = '0;
        avm_waitrequest = 1'b0;
        clear_stalls();
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_write", 32'(avm_write), 32'd0);
        chk("rst_addr", avm_address, 32'd0);
        chk("rst_data", avm_writedata, 32'd0);
        chk("rst_be", 32'(avm_byteenable), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Zero-wait slave, reference value.
        run_seq(24'h0A5F93, 1'b0, 1'b0);
        @(negedge clk);

        // Three stall cycles on digit 2.
        stall_len[2] = 3;
        run_seq(24'h0A5F93, 1'b0, 1'b0);
        clear_stalls();
        @(negedge clk);

        // Slave stuck from digit 1: timeout, then a fresh normal run.
        stall_len[1] = 999;
        run_seq(24'h123456, 1'b0, 1'b0);
        clear_stalls();
        run_seq(24'h789ABC, 1'b0, 1'b0);

        // Start pulses and value changes while busy are ignored.
        run_seq(24'hFEDCBA, 1'b1, 1'b0);
        @(negedge clk);

        // Start held high: each sequence begins after exactly one idle cycle.
        run_seq(24'h013579, 1'b0, 1'b1);
        run_seq(24'h2468AC, 1'b0, 1'b1);
        run_seq(24'hBDF0E1, 1'b0, 1'b0);
        @(negedge clk);

        // Asynchronous reset while digit 3 is on the bus.
        start = 1'b1;
        value = 24'($urandom);
        repeat (4) begin
            @(negedge clk);
            start = 1'b0;
        end
        chk("pre_rst_addr", avm_address, exp_addr(3));
        chk("pre_rst_write", 32'(avm_write), 32'd1);
        #1 reset = 1'b1;
        #1;
        chk("async_write", 32'(avm_write), 32'd0);
        chk("async_addr", avm_address, 32'd0);
        chk("async_data", avm_writedata, 32'd0);
        chk("async_be", 32'(avm_byteenable), 32'd0);
        chk("async_busy", 32'({busy, done, error}), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        run_seq(24'hFFFFFF, 1'b0, 1'b0);

        // Randomized values and stall patterns below the timeout.
        repeat (8) begin
            for (int k = 0; k < ND; k++) stall_len[k] = int'($urandom_range(0, TO - 1));
            run_seq(24'($urandom), 1'b0, 1'b0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // Randomized run with a random digit stalling past the timeout.
        clear_stalls();
        stall_len[$urandom_range(0, ND - 1)] = 999;
        run_seq(24'($urandom), 1'b0, 1'b0);
        clear_stalls();
        run_seq(24'($urandom), 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
